// File: rtl/demux1_4_latch.sv
// demux1_4_latch: registered 1-to-4 demultiplexer loaded by a debounced push button.
// Each accepted press writes din into the destination register chosen by s.
// Every destination register has a dirty flag. A press that bounces or is too
// short is ignored. Holding the button down produces exactly one write.
module demux1_4_latch #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       s,
    input  logic             btn,
    input  logic             clr,
    output logic [WIDTH-1:0] ya,
    output logic [WIDTH-1:0] yb,
    output logic [WIDTH-1:0] yc,
    output logic [WIDTH-1:0] yd,
    output logic [3:0]       dirty,
    output logic             wr,
    output logic             busy
);

    // The counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // button released and stable
        DOWN = 2'd1,  // button seen high, waiting for it to stay high
        HELD = 2'd2,  // press accepted and written, waiting for release
        UP   = 2'd3   // button seen low, waiting for it to stay low
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     wr_q;
    logic                     busy_q;
    logic                     sync1_q;
    logic                     btn_s_q;
    logic [3:0][WIDTH-1:0]    y_q;
    logic [3:0][WIDTH-1:0]    y_d;
    logic [3:0]               dirty_q;
    logic [3:0]               dirty_d;
    logic                     commit;

    // Two-flop synchronizer. Only this block reads the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old value of its
            // source, so this is a real two-stage shift and not a single wire.
            sync1_q <= btn;
            btn_s_q <= sync1_q;
        end
    end

    // A write commits on the edge where DOWN has seen enough stable high samples.
    assign commit = (state_q == DOWN) && btn_s_q && (cnt_q == CNT_MAX);

    // Debounce FSM. wr and busy are registered here together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s_q) begin
                        state_q <= DOWN;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                DOWN: begin
                    if (!btn_s_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        wr_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!btn_s_q) begin
                        state_q <= UP;
                        cnt_q   <= CNT_ONE;
                    end
                end
                UP: begin
                    if (btn_s_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next value of the destination registers. clr wipes all of them first.
    // A commit on the same edge then writes its own register.
    always_comb begin
        // NOTE: default every output of a combinational block first. Any path that
        // leaves an output unassigned would infer a latch.
        y_d     = y_q;
        dirty_d = dirty_q;
        if (clr) begin
            y_d     = '0;
            dirty_d = '0;
        end
        if (commit) begin
            y_d[s]     = din;
            dirty_d[s] = 1'b1;
        end
    end

    // Destination registers and dirty flags. rst overrides clr and any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            dirty_q <= '0;
        end else begin
            y_q     <= y_d;
            dirty_q <= dirty_d;
        end
    end

    assign ya    = y_q[0];
    assign yb    = y_q[1];
    assign yc    = y_q[2];
    assign yd    = y_q[3];
    assign dirty = dirty_q;
    assign wr    = wr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_demux1_4_latch.sv
// tb_demux1_4_latch: directed test of the debounced 1-to-4 demultiplexer
// with DEBOUNCE_CYCLES=4 and WIDTH=3. btn is always driven 1 ns after a rising edge.
// If btn then stays high, the write lands on the 6th rising edge after that
// point: 2 synchronizer edges, 1 edge to enter DOWN, and 3 more counting edges.
module tb_demux1_4_latch;

    localparam int WIDTH = 3;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic [1:0]       s;
    logic             btn;
    logic             clr;
    logic [WIDTH-1:0] ya, yb, yc, yd;
    logic [3:0]       dirty;
    logic             wr;
    logic             busy;

    int n_vec  = 0;
    int n_err  = 0;
    int wr_cnt = 0;
    int wr_ref;

    demux1_4_latch #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .s     (s),
        .btn   (btn),
        .clr   (clr),
        .ya    (ya),
        .yb    (yb),
        .yc    (yc),
        .yd    (yd),
        .dirty (dirty),
        .wr    (wr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Count the cycles in which wr is high. wr is registered, so sampling it on
    // the edge reads the value of the cycle that is just ending.
    always @(posedge clk) begin
        if (wr === 1'b1) wr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Move one rising edge forward and settle 1 ns past it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A full, clean press and release that ends with the FSM back in IDLE.
    task automatic press(input logic [1:0] sel, input logic [WIDTH-1:0] val);
        s   = sel;
        din = val;
        btn = 1'b1;
        tick(DEB + 2);
        btn = 1'b0;
        tick(DEB + 4);
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        s   = '0;
        btn = 1'b0;
        clr = 1'b0;

        // 1. Reset state
        tick(3);
        check("rst_ya", ya, 0);
        check("rst_yb", yb, 0);
        check("rst_yc", yc, 0);
        check("rst_yd", yd, 0);
        check("rst_dirty", dirty, 0);
        check("rst_wr", wr, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // 2. Basic write: din=101 goes to yc on the 6th edge
        wr_ref = wr_cnt;
        din = 3'b101;
        s   = 2'b10;
        btn = 1'b1;
        tick(3);
        check("t2_busy_down", busy, 1);
        tick(2);
        check("t2_yc_before", yc, 0);
        check("t2_wr_before", wr, 0);
        tick(1);
        check("t2_yc", yc, 5);
        check("t2_dirty", dirty, 4'b0100);
        check("t2_wr_high", wr, 1);
        check("t2_ya", ya, 0);
        check("t2_yb", yb, 0);
        check("t2_yd", yd, 0);
        tick(1);
        check("t2_wr_low", wr, 0);
        btn = 1'b0;
        tick(DEB + 4);
        check("t2_busy_idle", busy, 0);
        check("t2_wr_count", wr_cnt - wr_ref, 1);

        // 3. A 3-cycle pulse is too short and must not write
        wr_ref = wr_cnt;
        din = 3'b011;
        s   = 2'b00;
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(10);
        check("t3_wr_count", wr_cnt - wr_ref, 0);
        check("t3_busy", busy, 0);
        check("t3_ya", ya, 0);
        check("t3_dirty", dirty, 4'b0100);

        // 4. Bounce while HELD and change din: only one write, of the first din
        wr_ref = wr_cnt;
        din = 3'b111;
        s   = 2'b11;
        btn = 1'b1;
        tick(DEB + 2);
        check("t4_yd_commit", yd, 7);
        tick(2);
        btn = 1'b0;
        tick(2);
        btn = 1'b1;
        tick(3);
        din = 3'b001;
        tick(8);
        check("t4_busy_bounce", busy, 1);
        check("t4_yd_hold", yd, 7);
        btn = 1'b0;
        tick(DEB + 4);
        check("t4_yd_final", yd, 7);
        check("t4_wr_count", wr_cnt - wr_ref, 1);
        check("t4_busy_idle", busy, 0);
        check("t4_dirty", dirty, 4'b1100);

        // 5. Write all four registers, then a clr on the same edge as a commit
        press(2'b00, 3'd3);
        press(2'b01, 3'd6);
        press(2'b10, 3'd4);
        press(2'b11, 3'd2);
        check("t5_ya", ya, 3);
        check("t5_yb", yb, 6);
        check("t5_yc", yc, 4);
        check("t5_yd", yd, 2);
        check("t5_dirty_all", dirty, 4'b1111);
        s   = 2'b01;
        din = 3'b010;
        btn = 1'b1;
        tick(DEB + 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t5c_yb", yb, 2);
        check("t5c_dirty", dirty, 4'b0010);
        check("t5c_ya", ya, 0);
        check("t5c_yc", yc, 0);
        check("t5c_yd", yd, 0);
        check("t5c_wr", wr, 1);
        // clr on its own while HELD clears the registers but leaves the FSM busy
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t5d_yb", yb, 0);
        check("t5d_dirty", dirty, 0);
        check("t5d_busy", busy, 1);
        btn = 1'b0;
        tick(DEB + 4);
        check("t5d_busy_idle", busy, 0);

        // 6. rst during DOWN with btn held: a fresh, full debounce follows release
        wr_ref = wr_cnt;
        s   = 2'b00;
        din = 3'b110;
        btn = 1'b1;
        tick(3);
        check("t6_busy_down", busy, 1);
        rst = 1'b1;
        tick(2);
        check("t6_busy_rst", busy, 0);
        check("t6_wr_rst", wr, 0);
        rst = 1'b0;
        tick(DEB + 1);
        check("t6_ya_before", ya, 0);
        check("t6_wr_count_before", wr_cnt - wr_ref, 0);
        tick(1);
        check("t6_ya", ya, 6);
        check("t6_dirty", dirty, 4'b0001);
        check("t6_wr", wr, 1);
        btn = 1'b0;
        tick(DEB + 4);
        check("t6_wr_count", wr_cnt - wr_ref, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
